// File: rtl/id_issue_scheduler_if.sv
// Decode-to-scheduler bundle: decoded instruction fields, pipeline/branch
// status in, issue control and operand forward selects out.
interface id_issue_scheduler_if;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_we;
   logic       id_is_load;
   logic       id_is_mdu;
   logic       id_is_ctrl;
   logic       ex_ready;
   logic       mdu_done;
   logic       br_resolve;
   logic       br_taken;

   logic       id_ready;
   logic       issue;
   logic       bubble;
   logic       flush;
   logic [1:0] fwd1_sel;
   logic [1:0] fwd2_sel;
   logic       mdu_timeout;
   logic [1:0] state;

   // Decoder / pipeline side.
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
             id_is_load, id_is_mdu, id_is_ctrl, ex_ready, mdu_done, br_resolve, br_taken,
      input  id_ready, issue, bubble, flush, fwd1_sel, fwd2_sel, mdu_timeout, state
   );

   // Scheduler side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
             id_is_load, id_is_mdu, id_is_ctrl, ex_ready, mdu_done, br_resolve, br_taken,
      output id_ready, issue, bubble, flush, fwd1_sel, fwd2_sel, mdu_timeout, state
   );
endinterface

// File: rtl/id_issue_scheduler.sv
// Decode-stage issue scheduler: tracks EX/MEM/WB writers for forwarding and
// load-use stalls, blocks issue while MDU or control ops are outstanding.
module id_issue_scheduler #(
   parameter int FLUSH_CYC = 2,
   parameter int MDU_MAX   = 64,
   parameter int CW        = 7
) (
   input logic                clk,
   input logic                reset,
   id_issue_scheduler_if.slave sif
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MDU_WAIT  = 2'd1,
      ST_CTRL_WAIT = 2'd2,
      ST_FLUSH     = 2'd3
   } state_e;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } trk_t;

   localparam logic [CW-1:0] MDU_LAST   = CW'(MDU_MAX - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mdu_timeout_q, mdu_timeout_d;
   trk_t          ex_q, ex_d;
   trk_t          mem_q, mem_d;
   trk_t          wb_q, wb_d;

   logic          hz;
   logic          id_ready_c;
   logic          issue_c;
   logic          bubble_c;
   logic          flush_c;
   logic [1:0]    fwd1_c;
   logic [1:0]    fwd2_c;

   function automatic logic hit(trk_t e, logic [4:0] rs);
      return e.v & e.we & (e.rd == rs) & (rs != 5'd0);
   endfunction

   // Youngest writer wins: EX, then MEM, then WB.
   function automatic logic [1:0] fwd_pick(logic [4:0] rs, logic used,
                                           trk_t ex, trk_t mem, trk_t wb);
      if (!used)             return 2'd0;
      else if (hit(ex, rs))  return 2'd1;
      else if (hit(mem, rs)) return 2'd2;
      else if (hit(wb, rs))  return 2'd3;
      else                   return 2'd0;
   endfunction

   // Only a load still in EX stalls; once it reaches MEM its data forwards.
   assign hz = (sif.id_rs1_used & hit(ex_q, sif.id_rs1) & ex_q.ld) |
               (sif.id_rs2_used & hit(ex_q, sif.id_rs2) & ex_q.ld);

   assign fwd1_c     = fwd_pick(sif.id_rs1, sif.id_rs1_used, ex_q, mem_q, wb_q);
   assign fwd2_c     = fwd_pick(sif.id_rs2, sif.id_rs2_used, ex_q, mem_q, wb_q);
   assign id_ready_c = (state_q == ST_RUN) & sif.ex_ready & ~hz;
   assign issue_c    = sif.id_valid & id_ready_c;
   assign bubble_c   = sif.ex_ready & ~issue_c;
   assign flush_c    = (state_q == ST_FLUSH) |
                       ((state_q == ST_CTRL_WAIT) & sif.br_resolve & sif.br_taken);

   assign sif.id_ready    = reset & id_ready_c;
   assign sif.issue       = reset & issue_c;
   assign sif.bubble      = reset & bubble_c;
   assign sif.flush       = reset & flush_c;
   assign sif.fwd1_sel    = reset ? fwd1_c : 2'd0;
   assign sif.fwd2_sel    = reset ? fwd2_c : 2'd0;
   assign sif.mdu_timeout = mdu_timeout_q;
   assign sif.state       = state_q;

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path infers a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      mdu_timeout_d = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (issue_c && sif.id_is_mdu) begin
               state_d = ST_MDU_WAIT;
               cnt_d   = '0;
            end else if (issue_c && sif.id_is_ctrl) begin
               state_d = ST_CTRL_WAIT;
            end
         end
         ST_MDU_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (sif.mdu_done) begin
               state_d = ST_RUN;
            end else if (cnt_q == MDU_LAST) begin
               state_d       = ST_RUN;
               mdu_timeout_d = 1'b1;
            end
         end
         ST_CTRL_WAIT: begin
            if (sif.br_resolve && sif.br_taken) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else if (sif.br_resolve) begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == FLUSH_LAST) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (sif.ex_ready) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = issue_c ? '{v: 1'b1, rd: sif.id_rd, we: sif.id_we, ld: sif.id_is_load}
                         : '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         mdu_timeout_q <= 1'b0;
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mdu_timeout_q <= mdu_timeout_d;
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
      end
   end

endmodule

// File: tb/tb_id_issue_scheduler.sv
// Bench for id_issue_scheduler: directed vector table, multi-cycle corner
// sequences, and random traffic checked against a pipeline-queue model.
module tb_id_issue_scheduler;
   localparam int FLUSH_CYC = 2;
   localparam int MDU_MAX   = 64;
   localparam int CW        = 7;

   // Packed output word layout.
   localparam int B_RDY = 10;
   localparam int B_ISS = 9;
   localparam int B_BUB = 8;
   localparam int B_FL  = 7;
   localparam int B_TO  = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   id_issue_scheduler_if bus();

   id_issue_scheduler #(.FLUSH_CYC(FLUSH_CYC), .MDU_MAX(MDU_MAX), .CW(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .sif  (bus)
   );

   typedef struct {
      bit       rst_n;
      bit       valid;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit [4:0] rd;
      bit       u1, u2, we, ld, mdu, ctrl, exr, done, res, tkn;
   } in_t;

   typedef struct {
      in_t         i;
      logic [10:0] exp;
   } vec_t;

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } wr_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pipe[0]=EX, [1]=MEM, [2]=WB; wait conditions as flags/countdowns.
   wr_t pipe[3];
   bit  in_mdu, in_ctrl, m_to;
   int  mdu_age, flush_left;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   function automatic in_t mk(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit we, bit ld, bit exr);
      in_t r;
      r = '{default: 0};
      r.rst_n = 1'b1; r.valid = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
      r.rd = rd; r.we = we; r.ld = ld; r.exr = exr;
      return r;
   endfunction

   function automatic logic [10:0] xp(bit rdy, bit iss, bit bub, bit fl,
                                      bit [1:0] f1, bit [1:0] f2, bit [1:0] st);
      return {rdy, iss, bub, fl, f1, f2, 1'b0, st};
   endfunction

   function automatic logic [10:0] dut_out();
      return {bus.id_ready, bus.issue, bus.bubble, bus.flush, bus.fwd1_sel,
              bus.fwd2_sel, bus.mdu_timeout, bus.state};
   endfunction

   function automatic int m_fwd(bit [4:0] rs, bit used);
      if (!used || rs == 0) return 0;
      for (int s = 0; s < 3; s++)
         if (pipe[s].v && pipe[s].we && pipe[s].rd == rs) return s + 1;
      return 0;
   endfunction

   function automatic bit m_busy();
      return in_mdu || in_ctrl || (flush_left > 0);
   endfunction

   function automatic bit m_hz(in_t i);
      return pipe[0].ld && (m_fwd(i.rs1, i.u1) == 1 || m_fwd(i.rs2, i.u2) == 1);
   endfunction

   function automatic logic [10:0] m_expect(in_t i);
      bit       rdy, iss, bub, fl;
      bit [1:0] st;
      st = in_mdu ? 2'd1 : in_ctrl ? 2'd2 : (flush_left > 0) ? 2'd3 : 2'd0;
      if (!i.rst_n) return {8'd0, m_to, st};
      rdy = i.exr && !m_hz(i) && !m_busy();
      iss = i.valid && rdy;
      bub = i.exr && !iss;
      fl  = (flush_left > 0) || (in_ctrl && i.res && i.tkn);
      return {rdy, iss, bub, fl, 2'(m_fwd(i.rs1, i.u1)), 2'(m_fwd(i.rs2, i.u2)), m_to, st};
   endfunction

   task automatic m_step(input in_t i);
      bit iss, nto;
      if (!i.rst_n) begin
         for (int s = 0; s < 3; s++) pipe[s] = '{v: 0, rd: 0, we: 0, ld: 0};
         in_mdu = 0; in_ctrl = 0; flush_left = 0; mdu_age = 0; m_to = 0;
         return;
      end
      iss = i.valid && i.exr && !m_hz(i) && !m_busy();
      nto = 0;
      if (in_mdu) begin
         if (i.done) in_mdu = 0;
         else if (mdu_age == MDU_MAX - 1) begin in_mdu = 0; nto = 1; end
         else mdu_age++;
      end else if (in_ctrl) begin
         if (i.res) begin
            in_ctrl = 0;
            if (i.tkn) flush_left = FLUSH_CYC;
         end
      end else if (flush_left > 0) begin
         flush_left--;
      end else if (iss) begin
         if (i.mdu) begin in_mdu = 1; mdu_age = 0; end
         else if (i.ctrl) in_ctrl = 1;
      end
      if (i.exr) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = iss ? '{v: 1, rd: i.rd, we: i.we, ld: i.ld} : '{v: 0, rd: 0, we: 0, ld: 0};
      end
      m_to = nto;
   endtask

   task automatic drive(input in_t i);
      reset           = i.rst_n;
      bus.id_valid    = i.valid;
      bus.id_rs1      = i.rs1;
      bus.id_rs2      = i.rs2;
      bus.id_rs1_used = i.u1;
      bus.id_rs2_used = i.u2;
      bus.id_rd       = i.rd;
      bus.id_we       = i.we;
      bus.id_is_load  = i.ld;
      bus.id_is_mdu   = i.mdu;
      bus.id_is_ctrl  = i.ctrl;
      bus.ex_ready    = i.exr;
      bus.mdu_done    = i.done;
      bus.br_resolve  = i.res;
      bus.br_taken    = i.tkn;
   endtask

   // Drive after the edge, sample on the falling edge, advance the model with the edge.
   task automatic run_cycle(input in_t i, input string name, input bit use_tab,
                            input logic [10:0] tab_exp, output logic [10:0] got);
      logic [10:0] want;
      drive(i);
      @(negedge clk);
      got  = dut_out();
      want = use_tab ? tab_exp : m_expect(i);
      check(name, int'(got), int'(want));
      m_step(i);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input in_t i, input string name, output logic [10:0] got);
      run_cycle(i, name, 1'b0, 11'd0, got);
   endtask

   function automatic in_t rnd();
      in_t r;
      r.rst_n = ($urandom_range(0, 99) != 0);
      r.valid = ($urandom_range(0, 3) != 0);
      r.rs1   = 5'($urandom_range(0, 7));
      r.rs2   = 5'($urandom_range(0, 7));
      r.rd    = 5'($urandom_range(0, 7));
      r.u1    = ($urandom_range(0, 1) != 0);
      r.u2    = ($urandom_range(0, 1) != 0);
      r.we    = ($urandom_range(0, 3) != 0);
      r.ld    = ($urandom_range(0, 3) == 0);
      r.mdu   = ($urandom_range(0, 11) == 0);
      r.ctrl  = ($urandom_range(0, 9) == 0);
      r.exr   = ($urandom_range(0, 6) != 0);
      r.done  = ($urandom_range(0, 4) == 0);
      r.res   = ($urandom_range(0, 2) == 0);
      r.tkn   = ($urandom_range(0, 1) != 0);
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tab[18];
      in_t         i;
      logic [10:0] g;
      int          cnt, cnt_fl, waits, pulses, pulse_at;

      tab[0].i  = mk(1, 5, 1, 0, 0, 6, 1, 0, 1);  tab[0].i.rst_n = 0;
      tab[0].exp  = xp(0, 0, 0, 0, 0, 0, 0);
      tab[1].i  = mk(1, 1, 1, 0, 0, 5, 1, 1, 1);  tab[1].exp  = xp(1, 1, 0, 0, 0, 0, 0);
      tab[2].i  = mk(1, 5, 1, 7, 1, 6, 1, 0, 1);  tab[2].exp  = xp(0, 0, 1, 0, 1, 0, 0);
      tab[3].i  = mk(1, 5, 1, 7, 1, 6, 1, 0, 1);  tab[3].exp  = xp(1, 1, 0, 0, 2, 0, 0);
      tab[4].i  = mk(1, 5, 1, 0, 0, 3, 1, 0, 1);  tab[4].exp  = xp(1, 1, 0, 0, 3, 0, 0);
      tab[5].i  = mk(1, 3, 1, 3, 1, 4, 1, 0, 1);  tab[5].exp  = xp(1, 1, 0, 0, 1, 1, 0);
      tab[6].i  = mk(1, 6, 1, 0, 0, 0, 1, 0, 1);  tab[6].exp  = xp(1, 1, 0, 0, 3, 0, 0);
      tab[7].i  = mk(1, 0, 1, 0, 1, 9, 1, 0, 1);  tab[7].exp  = xp(1, 1, 0, 0, 0, 0, 0);
      tab[8].i  = mk(1, 9, 0, 4, 0, 0, 0, 0, 1);  tab[8].exp  = xp(1, 1, 0, 0, 0, 0, 0);
      tab[9].i  = mk(1, 0, 0, 0, 0, 10, 1, 1, 1); tab[9].exp  = xp(1, 1, 0, 0, 0, 0, 0);
      for (int k = 10; k <= 12; k++) begin
         tab[k].i = mk(1, 10, 1, 9, 1, 11, 1, 0, 0); tab[k].exp = xp(0, 0, 0, 0, 1, 3, 0);
      end
      tab[13].i = mk(1, 10, 1, 9, 1, 11, 1, 0, 1); tab[13].exp = xp(0, 0, 1, 0, 1, 3, 0);
      tab[14].i = mk(1, 10, 1, 9, 1, 11, 1, 0, 1); tab[14].exp = xp(1, 1, 0, 0, 2, 0, 0);
      tab[15].i = mk(0, 11, 1, 10, 1, 0, 0, 0, 1); tab[15].exp = xp(1, 0, 1, 0, 1, 3, 0);
      tab[16].i = mk(1, 11, 1, 0, 0, 11, 1, 0, 1); tab[16].exp = xp(1, 1, 0, 0, 2, 0, 0);
      tab[17].i = mk(1, 11, 1, 11, 1, 0, 0, 0, 1); tab[17].exp = xp(1, 1, 0, 0, 1, 1, 0);

      // Power-up reset: first edge only initialises, nothing is compared.
      i = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); i.rst_n = 0;
      drive(i);
      m_step(i);
      @(posedge clk);
      #1;
      cyc(i, "reset_hold", g);
      check("reset_state", int'(g), 0);
      i.rst_n = 1;
      cyc(i, "idle_after_reset", g);

      foreach (tab[k]) run_cycle(tab[k].i, $sformatf("vec%0d", k), 1'b1, tab[k].exp, g);

      // Taken branch: resolve ignored on issue cycle, then 2 waits, then redirect.
      i = mk(1, 1, 1, 2, 1, 0, 0, 0, 1); i.ctrl = 1; i.res = 1; i.tkn = 1;
      cyc(i, "beq_issue", g);
      check("beq_issued", int'(g[B_ISS]), 1);
      i = mk(1, 3, 1, 0, 0, 4, 1, 0, 1);
      cnt = 0;
      for (int k = 0; k < 2; k++) begin
         cyc(i, "ctrl_wait", g);
         cnt += int'(g[B_RDY]);
      end
      i.res = 1; i.tkn = 1;
      cyc(i, "redirect", g);
      check("redirect_flush", int'(g[B_FL]), 1);
      cnt += int'(g[B_RDY]);
      cnt_fl = 0;
      for (int k = 0; k < 10; k++) begin
         cyc(i, "flush_cycle", g);
         if (g[1:0] != 2'd3) break;
         cnt_fl += int'(g[B_FL]);
         cnt    += int'(g[B_RDY]);
      end
      check("flush_len", cnt_fl, FLUSH_CYC);
      check("ctrl_ready_low", cnt, 0);
      check("ctrl_back_to_run", int'(g[1:0]), 0);

      // MDU op, done on the 10th wait cycle.
      i = mk(1, 0, 0, 0, 0, 8, 1, 0, 1); i.mdu = 1;
      cyc(i, "div_issue", g);
      check("div_issued", int'(g[B_ISS]), 1);
      i = mk(1, 0, 0, 0, 0, 9, 1, 0, 1);
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         i.done = (k == 10);
         cyc(i, "mdu_wait", g);
         cnt += int'(!g[B_RDY]);
      end
      check("mdu_stall_len", cnt, 10);
      i.done = 0;
      cyc(i, "mdu_resume", g);
      check("mdu_resume_issue", int'(g[B_ISS]), 1);

      // MDU op with no done: timeout pulse one cycle after the last wait cycle.
      i = mk(1, 0, 0, 0, 0, 8, 1, 0, 1); i.mdu = 1;
      cyc(i, "div2_issue", g);
      i = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      waits = 0; pulses = 0; pulse_at = -1;
      for (int k = 0; k < MDU_MAX + 6; k++) begin
         cyc(i, "mdu_timeout_wait", g);
         if (g[1:0] == 2'd1) waits++;
         if (g[B_TO]) begin pulses++; pulse_at = k; end
      end
      check("timeout_waits", waits, MDU_MAX);
      check("timeout_pulses", pulses, 1);
      check("timeout_pulse_at", pulse_at, MDU_MAX);

      // Done on the same cycle the timeout would fire: done wins.
      i = mk(1, 0, 0, 0, 0, 8, 1, 0, 1); i.mdu = 1;
      cyc(i, "div3_issue", g);
      i = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      waits = 0; pulses = 0;
      for (int k = 0; k < MDU_MAX + 4; k++) begin
         i.done = (k == MDU_MAX - 1);
         cyc(i, "mdu_done_last", g);
         if (g[1:0] == 2'd1) waits++;
         if (g[B_TO]) pulses++;
      end
      check("done_last_waits", waits, MDU_MAX);
      check("done_last_no_pulse", pulses, 0);

      // Reset while flushing, with x7 held in MEM by ex_ready=0.
      i = mk(1, 0, 0, 0, 0, 7, 1, 0, 1);
      cyc(i, "wr_x7", g);
      i = mk(1, 7, 1, 0, 0, 0, 0, 0, 1); i.ctrl = 1;
      cyc(i, "beq_x7", g);
      check("beq_x7_fwd", int'(g[6:5]), 1);
      i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); i.res = 1; i.tkn = 1;
      cyc(i, "resolve_hold", g);
      i.res = 0; i.tkn = 0;
      cyc(i, "flush_hold", g);
      check("in_flush", int'(g[1:0]), 3);
      i.rst_n = 0;
      cyc(i, "reset_in_flush", g);
      check("reset_flush_low", int'(g[B_FL]), 0);
      i = mk(1, 7, 1, 7, 1, 0, 0, 0, 0);
      cyc(i, "post_reset", g);
      check("post_reset_state", int'(g[1:0]), 0);
      check("post_reset_flush", int'(g[B_FL]), 0);
      check("post_reset_fwd", int'(g[6:3]), 0);

      for (int k = 0; k < 3000; k++) cyc(rnd(), "rand", g);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
